// File: rtl/fact_sched.sv
// rtl/fact_sched.sv - job FIFO and round-robin dispatcher for four factorial units
//
// Purpose: software pushes 4-bit operands through a bus register window; queued
// jobs are handed to idle factorial units in round-robin order, one per cycle.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           synchronous active-high reset
//   input_addr    bus address (shared with interrupt-controller writes)
//   write_enable  bus write strobe
//   write_data    bus write data
//   read_data     combinational register read, 0 outside the window
//   done          per-unit completion pulse
//   unit_go       registered one-cycle start pulse per unit
//   unit_n        operand for unit i in bits [4i+3:4i]
//   sched_err     overflow | spurious
module fact_sched #(
  parameter logic [31:0] BASE_ADDR = 32'h00007000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic [3:0]  done,
  output logic [3:0]  unit_go,
  output logic [15:0] unit_n,
  output logic        sched_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    busy;
  logic [1:0]    last_grant;
  logic [3:0]    last_n;
  logic          enable;
  logic          overflow;
  logic          spurious;

  logic          job_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          clear_err;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    head;
  logic          push;
  logic          ovf_ev;
  logic          spur_ev;
  logic          found;
  logic [1:0]    grant_idx;
  logic [3:0]    grant_vec;
  logic          unused_bits;

  assign job_wr     = write_enable && (input_addr == BASE_ADDR);
  assign ctrl_wr    = write_enable && (input_addr == BASE_ADDR + 32'd12);
  assign flush      = ctrl_wr && write_data[1];
  assign clear_err  = ctrl_wr && write_data[2];
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // A full-queue write overflows even when a pop frees a slot this cycle;
  // a write coinciding with flush is silently discarded.
  assign push    = job_wr && !flush && !fifo_full;
  assign ovf_ev  = job_wr && !flush && fifo_full;
  assign spur_ev = |(done & ~busy);

  assign sched_err   = overflow | spurious;
  assign unused_bits = ^write_data[31:4];

  // Round-robin search starting just after the previous grant. A unit whose
  // done pulse arrives this cycle still counts as busy for this decision.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_grant;
    if (enable && !fifo_empty && !flush) begin
      for (int k = 1; k <= 4; k++) begin
        if (!found && !busy[last_grant + 2'(k)]) begin
          found     = 1'b1;
          grant_idx = last_grant + 2'(k);
        end
      end
    end
    grant_vec = found ? (4'b0001 << grant_idx) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= write_data[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      last_grant <= 2'd3;
      last_n     <= '0;
      enable     <= 1'b0;
      overflow   <= 1'b0;
      spurious   <= 1'b0;
      unit_go    <= '0;
      unit_n     <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (found) begin
          rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(found);
      end

      busy    <= (busy & ~done) | grant_vec;
      unit_go <= grant_vec;
      if (found) begin
        unit_n[{grant_idx, 2'b00} +: 4] <= head;
        last_grant                      <= grant_idx;
        last_n                          <= head;
      end

      if (ctrl_wr) begin
        enable <= write_data[0];
      end
      // A new error event beats a simultaneous clear.
      overflow <= ovf_ev  | (overflow & ~clear_err);
      spurious <= spur_ev | (spurious & ~clear_err);
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (input_addr == BASE_ADDR + 32'd4) begin
      read_data = {14'd0, spurious, overflow, 4'd0, busy, 3'd0,
                   fifo_empty, fifo_full, 3'(count)};
    end else if (input_addr == BASE_ADDR + 32'd8) begin
      read_data = {24'd0, last_n, 2'd0, last_grant};
    end else if (input_addr == BASE_ADDR + 32'd12) begin
      read_data = {31'd0, enable};
    end
  end

endmodule
